// File: rtl/afe_seq_pkg.sv
// Shared definitions for the AFE injection sequencer: FSM state encoding,
// default field widths and the "zero means one" clamp used on timing fields.
package afe_seq_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_NP_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    // Timing fields where a zero length makes no sense are bumped to one.
    // Works on a 32-bit carrier so callers of any field width can share it.
    function automatic logic [31:0] clamp_min1(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/afe_sync2.sv
// Two-flop synchroniser followed by an edge register; produces a one-cycle
// rising-edge strobe in the clk domain for an asynchronous level input.
module afe_sync2 (
    input  logic clk,
    input  logic rst_b,
    input  logic async_in,
    output logic rise
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    // Metastability filter plus previous-value register for edge detection
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/afe_inj_sequencer.sv
// Charge-injection pulse-train sequencer: generates INJ and a delayed copy
// INJ_DEL, counts completed pulses and (optionally) pulses that produced a
// comparator response.
// Build option: define AFE_SEQ_HITCNT_EN to include the COMP synchroniser,
// hit flag and HIT_CNT; without it HIT_CNT is tied to zero and COMP is unused.
module afe_inj_sequencer
    import afe_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NP_W  = DEF_NP_W
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] CFG_HIGH,
    input  logic [CNT_W-1:0] CFG_DEL,
    input  logic [CNT_W-1:0] CFG_GAP,
    input  logic [NP_W-1:0]  CFG_NPULSE,
    input  logic             COMP,
    output logic             INJ,
    output logic             INJ_DEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [NP_W-1:0]  PULSE_CNT,
    output logic [NP_W-1:0]  HIT_CNT
);

    // Phase counter is one bit wider so HIGH+DEL never wraps.
    localparam int T_W = CNT_W + 1;

    function automatic logic [NP_W-1:0] sat_inc(input logic [NP_W-1:0] value);
        return (&value) ? value : value + NP_W'(1);
    endfunction

    seq_state_t       state_q;
    logic [T_W-1:0]   t_q;
    logic [CNT_W-1:0] gap_cnt_q;

    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] del_q;
    logic [CNT_W-1:0] gap_q;
    logic [NP_W-1:0]  npulse_q;

    logic             accept;
    logic [T_W-1:0]   high_ext;
    logic [T_W-1:0]   del_ext;
    logic [T_W-1:0]   pulse_last;
    logic [T_W-1:0]   t_next;
    logic             pulse_end;
    logic             gap_end;
    logic             run_done;

    assign accept     = (state_q == IDLE) && START && !ABORT;
    assign high_ext   = {1'b0, high_q};
    assign del_ext    = {1'b0, del_q};
    assign pulse_last = high_ext + del_ext - T_W'(1);
    assign t_next     = t_q + T_W'(1);
    assign pulse_end  = (state_q == PULSE) && (t_q == pulse_last);
    assign gap_end    = (gap_cnt_q == gap_q - CNT_W'(1));
    assign run_done   = (npulse_q != '0) && (PULSE_CNT == npulse_q);

    // Configuration shadow registers, captured only when a run is accepted
    always_ff @(posedge CLK) begin
        if (accept) begin
            high_q   <= CNT_W'(clamp_min1(32'(CFG_HIGH)));
            del_q    <= CFG_DEL;
            gap_q    <= CNT_W'(clamp_min1(32'(CFG_GAP)));
            npulse_q <= CFG_NPULSE;
        end
    end

    // Sequencer FSM with registered strobes, status and pulse counter
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q   <= IDLE;
            t_q       <= '0;
            gap_cnt_q <= '0;
            INJ       <= 1'b0;
            INJ_DEL   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PULSE_CNT <= '0;
        end else begin
            DONE <= 1'b0;
            if (ABORT) begin
                state_q <= IDLE;
                INJ     <= 1'b0;
                INJ_DEL <= 1'b0;
                BUSY    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (START) begin
                            // Shadows load on this same edge, so use the live delay here.
                            state_q   <= PULSE;
                            t_q       <= '0;
                            PULSE_CNT <= '0;
                            INJ       <= 1'b1;
                            INJ_DEL   <= (CFG_DEL == '0);
                            BUSY      <= 1'b1;
                        end
                    end
                    PULSE: begin
                        if (pulse_end) begin
                            state_q   <= GAP;
                            gap_cnt_q <= '0;
                            INJ       <= 1'b0;
                            INJ_DEL   <= 1'b0;
                            PULSE_CNT <= sat_inc(PULSE_CNT);
                        end else begin
                            t_q     <= t_next;
                            INJ     <= (t_next < high_ext);
                            INJ_DEL <= (t_next >= del_ext);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            if (run_done) begin
                                state_q <= FINISH;
                            end else begin
                                state_q <= PULSE;
                                t_q     <= '0;
                                INJ     <= 1'b1;
                                INJ_DEL <= (del_q == '0);
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + CNT_W'(1);
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef AFE_SEQ_HITCNT_EN
    logic comp_rise;
    logic hit_q;

    afe_sync2 u_comp_sync (
        .clk      (CLK),
        .rst_b    (RST_B),
        .async_in (COMP),
        .rise     (comp_rise)
    );

    // Per-pulse hit flag; an edge arriving on the closing edge still counts
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            hit_q   <= 1'b0;
            HIT_CNT <= '0;
        end else if (!ABORT) begin
            if (accept) begin
                hit_q   <= 1'b0;
                HIT_CNT <= '0;
            end else if (pulse_end) begin
                hit_q <= 1'b0;
                if (hit_q || comp_rise) begin
                    HIT_CNT <= sat_inc(HIT_CNT);
                end
            end else if ((state_q == PULSE) && comp_rise) begin
                hit_q <= 1'b1;
            end
        end
    end
`else
    logic unused_comp;
    assign unused_comp = COMP;
    assign HIT_CNT     = '0;
`endif

endmodule
